// File: rtl/dp_hpd_detector.sv
// rtl/dp_hpd_detector.sv - HPD pin qualifier producing HPD_Detect, HPD_IRQ and HPD_Unplug.
// One duration counter and a four-state FSM classify connect, IRQ, glitch and unplug events.
module dp_hpd_detector #(
  parameter int SYNC_STAGES   = 2,
  parameter int T_CONNECT_CYC = 200000,
  parameter int T_IRQ_MIN_CYC = 50000,
  parameter int T_IRQ_MAX_CYC = 100000,
  parameter int T_UNPLUG_CYC  = 200000,
  parameter int CNT_WIDTH     = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic HPD_Pin,
  output logic HPD_Detect,
  output logic HPD_IRQ,
  output logic HPD_Unplug
);

  generate
    if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (!((T_IRQ_MIN_CYC <= T_IRQ_MAX_CYC) && (T_IRQ_MAX_CYC < T_UNPLUG_CYC))) begin : g_chk_order
      $error("thresholds must satisfy T_IRQ_MIN_CYC <= T_IRQ_MAX_CYC < T_UNPLUG_CYC");
    end
    if ((longint'(T_CONNECT_CYC) >= (longint'(1) << CNT_WIDTH)) ||
        (longint'(T_UNPLUG_CYC) >= (longint'(1) << CNT_WIDTH))) begin : g_chk_width
      $error("CNT_WIDTH too small for the largest threshold");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DISCONNECTED,
    ST_CONNECT_WAIT,
    ST_CONNECTED,
    ST_LOW_MEASURE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CONNECT = CNT_WIDTH'(T_CONNECT_CYC);
  localparam logic [CNT_WIDTH-1:0] C_IRQ_MIN = CNT_WIDTH'(T_IRQ_MIN_CYC);
  localparam logic [CNT_WIDTH-1:0] C_IRQ_MAX = CNT_WIDTH'(T_IRQ_MAX_CYC);
  localparam logic [CNT_WIDTH-1:0] C_UNPLUG  = CNT_WIDTH'(T_UNPLUG_CYC);
  localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_hpd_s;
  state_t                 r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic                   r_detect, r_irq, r_unplug;
  logic                   w_detect_nxt, w_irq_nxt, w_unplug_nxt;

  assign w_hpd_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], HPD_Pin};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;
    w_irq_nxt    = 1'b0;
    w_unplug_nxt = 1'b0;
    case (r_state)
      ST_DISCONNECTED: begin
        w_cnt_nxt = '0;
        if (w_hpd_s) begin
          w_state_nxt = ST_CONNECT_WAIT;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_CONNECT_WAIT: begin
        if (!w_hpd_s) begin
          w_state_nxt = ST_DISCONNECTED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= C_CONNECT) begin
          w_state_nxt = ST_CONNECTED;
          w_cnt_nxt   = '0;
        end
      end
      ST_CONNECTED: begin
        w_cnt_nxt = '0;
        if (!w_hpd_s) begin
          w_state_nxt = ST_LOW_MEASURE;
          w_cnt_nxt   = C_ONE;
        end
      end
      ST_LOW_MEASURE: begin
        // Threshold wins over a coincident rising sample; that sample is not reused.
        if (r_cnt >= C_UNPLUG) begin
          w_state_nxt  = ST_DISCONNECTED;
          w_cnt_nxt    = '0;
          w_unplug_nxt = 1'b1;
        end else if (w_hpd_s) begin
          w_state_nxt = ST_CONNECTED;
          w_cnt_nxt   = '0;
          w_irq_nxt   = (r_cnt >= C_IRQ_MIN) && (r_cnt <= C_IRQ_MAX);
        end
      end
      default: begin
        w_state_nxt = ST_DISCONNECTED;
        w_cnt_nxt   = '0;
      end
    endcase
    w_detect_nxt = (w_state_nxt == ST_CONNECTED) || (w_state_nxt == ST_LOW_MEASURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_DISCONNECTED;
      r_cnt    <= '0;
      r_detect <= 1'b0;
      r_irq    <= 1'b0;
      r_unplug <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_detect <= w_detect_nxt;
      r_irq    <= w_irq_nxt;
      r_unplug <= w_unplug_nxt;
    end
  end

  assign HPD_Detect = r_detect;
  assign HPD_IRQ    = r_irq;
  assign HPD_Unplug = r_unplug;

endmodule

// File: tb/tb_dp_hpd_detector.sv
// tb/tb_dp_hpd_detector.sv - scoreboard bench for dp_hpd_detector with a segment-level reference model.
module tb_dp_hpd_detector;

  localparam int SYNC  = 3;
  localparam int T_CON = 40;
  localparam int T_MIN = 10;
  localparam int T_MAX = 20;
  localparam int T_UNP = 40;
  localparam int CW    = 6;

  localparam int EV_CONNECT = 0;
  localparam int EV_IRQ     = 1;
  localparam int EV_UNPLUG  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic HPD_Pin = 1'b0;
  logic HPD_Detect, HPD_IRQ, HPD_Unplug;

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t exp_q[$];
  bit  m_conn = 1'b0;
  bit  m_skip = 1'b0;
  bit  prev_det = 1'b0;
  bit  lvl;

  dp_hpd_detector #(
    .SYNC_STAGES  (SYNC),
    .T_CONNECT_CYC(T_CON),
    .T_IRQ_MIN_CYC(T_MIN),
    .T_IRQ_MAX_CYC(T_MAX),
    .T_UNPLUG_CYC (T_UNP),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .HPD_Pin   (HPD_Pin),
    .HPD_Detect(HPD_Detect),
    .HPD_IRQ   (HPD_IRQ),
    .HPD_Unplug(HPD_Unplug)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Reference model: each constant-level segment is classified from its length alone.
  task automatic seg(input bit level, input int n);
    int t;
    t = cyc + SYNC + 1;
    if (level) begin
      if (!m_conn && (n - int'(m_skip) >= T_CON + 1)) begin
        push(EV_CONNECT, t + int'(m_skip) + T_CON);
        m_conn = 1'b1;
      end
      m_skip = 1'b0;
    end else if (m_conn) begin
      if (n >= T_UNP) begin
        push(EV_UNPLUG, t + T_UNP);
        m_conn = 1'b0;
        m_skip = (n == T_UNP);
      end else if (n >= T_MIN && n <= T_MAX) begin
        push(EV_IRQ, t + n);
      end
    end
    repeat (n) begin
      HPD_Pin = level;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_det = 1'b0;
    end else begin
      if (HPD_Detect && !prev_det) observe(EV_CONNECT);
      if (HPD_IRQ) begin
        check("irq_excl", {30'd0, HPD_Unplug, HPD_Detect}, 32'd1);
        observe(EV_IRQ);
      end
      if (HPD_Unplug || (prev_det && !HPD_Detect)) begin
        check("unplug_with_fall", {29'd0, HPD_Unplug, HPD_Detect, prev_det}, 32'b101);
        observe(EV_UNPLUG);
      end
      prev_det = HPD_Detect;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, required finish within budget");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  function automatic int rand_low();
    int b[9] = '{9, 10, 11, 19, 20, 21, 39, 40, 41};
    if ($urandom_range(0, 1) == 0) return b[$urandom_range(0, 8)];
    return $urandom_range(1, 50);
  endfunction

  function automatic int rand_high();
    if ($urandom_range(0, 3) == 0) return $urandom_range(40, 42);
    return $urandom_range(1, 60);
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_detect", {31'd0, HPD_Detect}, 32'd0);
    check("reset_irq", {31'd0, HPD_IRQ}, 32'd0);
    check("reset_unplug", {31'd0, HPD_Unplug}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    seg(0, 5);
    seg(1, 30); seg(0, 3); seg(1, 60);
    seg(0, 9);  seg(1, 10); seg(0, 10); seg(1, 10); seg(0, 15); seg(1, 10);
    seg(0, 20); seg(1, 10); seg(0, 21); seg(1, 10);
    seg(0, 3);  seg(1, 10);
    seg(0, 30); seg(1, 10);
    seg(0, 40); seg(1, 50);
    seg(0, 45); seg(1, 45);

    lvl = 1'b0;
    for (int i = 0; i < 150; i++) begin
      seg(lvl, lvl ? rand_high() : rand_low());
      lvl = ~lvl;
    end
    if (lvl) seg(1'b0, rand_low());
    seg(1, 80);

    HPD_Pin = 1'b0;
    repeat (17) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_detect", {31'd0, HPD_Detect}, 32'd0);
    check("midrst_irq", {31'd0, HPD_IRQ}, 32'd0);
    check("midrst_unplug", {31'd0, HPD_Unplug}, 32'd0);
    HPD_Pin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_conn = 1'b0;
    m_skip = 1'b0;
    seg(1, 60);

    repeat (10) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
